multicycle_cu: RTL and testbench

MULTICYCLE_CU -- requirements
Module: multicycle_cu

---
 rtl/multicycle_cu.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait
// timeout, registered status pulses and combinational datapath controls.
module multicycle_cu #(
   parameter int OPW         = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           go,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           PCWrite,
   output logic           IRWrite,
   output logic           RegDst,
   output logic           ALUSrc,
   output logic           MemToReg,
   output logic           RegWrite,
   output logic           MemRead,
   output logic           MemWrite,
   output logic [1:0]     ALUOp,
   output logic [2:0]     state,
   output logic           instr_done,
   output logic           illegal_op,
   output logic           mem_timeout
);

   localparam int             CW     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam bit             TO_EN  = (MEM_TIMEOUT > 0);
   localparam logic [CW-1:0]  TO_VAL = CW'(MEM_TIMEOUT);
   localparam logic [OPW-1:0] OP_R   = OPW'(0);
   localparam logic [OPW-1:0] OP_I   = OPW'(1);
   localparam logic [OPW-1:0] OP_LW  = OPW'(2);
   localparam logic [OPW-1:0] OP_SW  = OPW'(3);
   localparam logic [OPW-1:0] OP_BEQ = OPW'(4);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [OPW-1:0] r_op_q;
   logic [CW-1:0]  r_wait_cnt;
   logic           r_instr_done;
   logic           r_illegal_op;
   logic           r_mem_timeout;

   logic           w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq;
   logic           w_to_hit;
   logic           w_waiting;
   logic           w_done_set, w_illegal_set, w_timeout_set;
   logic           w_pc_write, w_ir_write, w_reg_dst, w_alu_src;
   logic           w_mem_to_reg, w_reg_write, w_mem_read, w_mem_write;
   logic [1:0]     w_alu_op;

   assign w_is_r   = (r_op_q == OP_R);
   assign w_is_i   = (r_op_q == OP_I);
   assign w_is_lw  = (r_op_q == OP_LW);
   assign w_is_sw  = (r_op_q == OP_SW);
   assign w_is_beq = (r_op_q == OP_BEQ);
   assign w_to_hit = TO_EN && (r_wait_cnt == TO_VAL);

   // State, latched opcode, wait counter and status pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_FETCH;
         r_op_q        <= '0;
         r_wait_cnt    <= '0;
         r_instr_done  <= 1'b0;
         r_illegal_op  <= 1'b0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_wait_cnt    <= w_waiting ? (r_wait_cnt + CW'(1)) : '0;
         r_instr_done  <= w_done_set;
         r_illegal_op  <= w_illegal_set;
         r_mem_timeout <= w_timeout_set;
         if (r_state == S_DECODE) begin
            r_op_q <= opcode;
         end else begin
            r_op_q <= r_op_q;
         end
      end
   end

   // Next-state, datapath controls and status pulse triggers
   always_comb begin
      w_next_state  = r_state;
      w_waiting     = 1'b0;
      w_done_set    = 1'b0;
      w_illegal_set = 1'b0;
      w_timeout_set = 1'b0;
      w_pc_write    = 1'b0;
      w_ir_write    = 1'b0;
      w_reg_dst     = 1'b0;
      w_alu_src     = 1'b0;
      w_mem_to_reg  = 1'b0;
      w_reg_write   = 1'b0;
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_alu_op      = 2'b00;
      case (r_state)
         S_FETCH: begin
            if (go) begin
               w_mem_read = 1'b1;
               if (mem_ready) begin
                  w_pc_write   = 1'b1;
                  w_ir_write   = 1'b1;
                  w_next_state = S_DECODE;
               end else if (w_to_hit) begin
                  w_timeout_set = 1'b1;
                  w_next_state  = S_FETCH;
               end else begin
                  w_waiting = 1'b1;
               end
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_DECODE: begin
            // The raw opcode is judged here because r_op_q only loads at this edge
            if (opcode <= OP_BEQ) begin
               w_next_state = S_EXEC;
            end else begin
               w_illegal_set = 1'b1;
               w_next_state  = S_FETCH;
            end
         end
         S_EXEC: begin
            if (w_is_r) begin
               w_alu_op     = 2'b10;
               w_next_state = S_WB;
            end else if (w_is_i) begin
               w_alu_src    = 1'b1;
               w_alu_op     = 2'b10;
               w_next_state = S_WB;
            end else if (w_is_lw || w_is_sw) begin
               w_alu_src    = 1'b1;
               w_alu_op     = 2'b00;
               w_next_state = S_MEM;
            end else if (w_is_beq) begin
               w_alu_op     = 2'b01;
               w_pc_write   = zero;
               w_done_set   = 1'b1;
               w_next_state = S_FETCH;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_MEM: begin
            w_mem_read  = w_is_lw;
            w_mem_write = w_is_sw;
            if (mem_ready) begin
               if (w_is_lw) begin
                  w_next_state = S_WB;
               end else begin
                  w_done_set   = w_is_sw;
                  w_next_state = S_FETCH;
               end
            end else if (w_to_hit) begin
               w_timeout_set = 1'b1;
               w_next_state  = S_FETCH;
            end else begin
               w_waiting = 1'b1;
            end
         end
         S_WB: begin
            w_reg_write  = 1'b1;
            w_reg_dst    = w_is_r;
            w_mem_to_reg = w_is_lw;
            w_done_set   = 1'b1;
            w_next_state = S_FETCH;
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   // Controls are forced low for as long as reset is held, not just at the edge
   assign PCWrite  = w_pc_write   & ~reset;
   assign IRWrite  = w_ir_write   & ~reset;
   assign RegDst   = w_reg_dst    & ~reset;
   assign ALUSrc   = w_alu_src    & ~reset;
   assign MemToReg = w_mem_to_reg & ~reset;
   assign RegWrite = w_reg_write  & ~reset;
   assign MemRead  = w_mem_read   & ~reset;
   assign MemWrite = w_mem_write  & ~reset;
   assign ALUOp    = reset ? 2'b00 : w_alu_op;

   assign state       = r_state;
   assign instr_done  = r_instr_done;
   assign illegal_op  = r_illegal_op;
   assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed self-checking bench for multicycle_cu: per-cycle state, control
// vector and status pulse checks against hand-derived expectations.
module tb_multicycle_cu;

   localparam int OPW = 4;

   // Control vector order: PCWrite IRWrite RegDst ALUSrc MemToReg RegWrite MemRead MemWrite ALUOp[1:0]
   localparam logic [9:0] C_IDLE       = 10'b0000000000;
   localparam logic [9:0] C_FETCH_WAIT = 10'b0000001000;
   localparam logic [9:0] C_FETCH_DONE = 10'b1100001000;
   localparam logic [9:0] C_EX_R       = 10'b0000000010;
   localparam logic [9:0] C_EX_I       = 10'b0001000010;
   localparam logic [9:0] C_EX_MEM     = 10'b0001000000;
   localparam logic [9:0] C_EX_BEQ0    = 10'b0000000001;
   localparam logic [9:0] C_EX_BEQ1    = 10'b1000000001;
   localparam logic [9:0] C_MEM_LW     = 10'b0000001000;
   localparam logic [9:0] C_MEM_SW     = 10'b0000000100;
   localparam logic [9:0] C_WB_R       = 10'b0010010000;
   localparam logic [9:0] C_WB_I       = 10'b0000010000;
   localparam logic [9:0] C_WB_LW      = 10'b0000110000;
   // Status order: instr_done illegal_op mem_timeout
   localparam logic [2:0] S_NONE = 3'b000;
   localparam logic [2:0] S_DONE = 3'b100;
   localparam logic [2:0] S_ILL  = 3'b010;
   localparam logic [2:0] S_TO   = 3'b001;

   logic           clk;
   logic           reset;
   logic           go;
   logic [OPW-1:0] opcode;
   logic           zero;
   logic           mem_ready;
   logic           PCWrite, IRWrite, RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite;
   logic [1:0]     ALUOp;
   logic [2:0]     state;
   logic           instr_done, illegal_op, mem_timeout;
   logic [9:0]     ctl;
   logic [2:0]     stat;

   int n_checks = 0;
   int n_errors = 0;

   multicycle_cu #(.OPW(OPW), .MEM_TIMEOUT(15)) dut (
      .clk         (clk),
      .reset       (reset),
      .go          (go),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .IRWrite     (IRWrite),
      .RegDst      (RegDst),
      .ALUSrc      (ALUSrc),
      .MemToReg    (MemToReg),
      .RegWrite    (RegWrite),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .ALUOp       (ALUOp),
      .state       (state),
      .instr_done  (instr_done),
      .illegal_op  (illegal_op),
      .mem_timeout (mem_timeout)
   );

   assign ctl  = {PCWrite, IRWrite, RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp};
   assign stat = {instr_done, illegal_op, mem_timeout};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Check one cycle at the falling edge, then advance past the next rising edge
   task automatic cyc(input string tag, input logic [2:0] es, input logic [9:0] ec, input logic [2:0] est);
      @(negedge clk);
      check({tag, "_state"}, {29'd0, state}, {29'd0, es});
      check({tag, "_ctl"},   {22'd0, ctl},   {22'd0, ec});
      check({tag, "_stat"},  {29'd0, stat},  {29'd0, est});
      @(posedge clk);
      #1;
   endtask

   // Zero-wait fetch followed by the DECODE cycle
   task automatic fetch_decode(input string tag, input logic [OPW-1:0] op);
      go        = 1'b1;
      mem_ready = 1'b1;
      opcode    = op;
      cyc({tag, "_fetch"}, 3'd0, C_FETCH_DONE, S_NONE);
      go        = 1'b0;
      mem_ready = 1'b0;
      cyc({tag, "_decode"}, 3'd1, C_IDLE, S_NONE);
   endtask

   initial begin
      reset     = 1'b1;
      go        = 1'b1;
      mem_ready = 1'b1;
      opcode    = '0;
      zero      = 1'b0;

      @(negedge clk);
      check("reset_state", {29'd0, state}, 32'd0);
      check("reset_ctl",   {22'd0, ctl},   32'd0);
      check("reset_stat",  {29'd0, stat},  32'd0);
      go        = 1'b0;
      mem_ready = 1'b0;
      reset     = 1'b0;
      @(posedge clk);
      #1;
      cyc("idle", 3'd0, C_IDLE, S_NONE);

      // R-type: 4 cycles, RegDst in WB
      fetch_decode("r", 4'd0);
      cyc("r_exec", 3'd2, C_EX_R, S_NONE);
      cyc("r_wb",   3'd4, C_WB_R, S_NONE);
      cyc("r_done", 3'd0, C_IDLE, S_DONE);

      // Immediate
      fetch_decode("i", 4'd1);
      cyc("i_exec", 3'd2, C_EX_I, S_NONE);
      cyc("i_wb",   3'd4, C_WB_I, S_NONE);
      cyc("i_done", 3'd0, C_IDLE, S_DONE);

      // LW with three wait cycles: latency 8
      fetch_decode("lw", 4'd2);
      cyc("lw_exec", 3'd2, C_EX_MEM, S_NONE);
      for (int i = 0; i < 3; i++) begin
         cyc("lw_memwait", 3'd3, C_MEM_LW, S_NONE);
      end
      mem_ready = 1'b1;
      cyc("lw_memrdy", 3'd3, C_MEM_LW, S_NONE);
      mem_ready = 1'b0;
      cyc("lw_wb",   3'd4, C_WB_LW, S_NONE);
      cyc("lw_done", 3'd0, C_IDLE, S_DONE);

      // SW zero wait: 4 cycles
      fetch_decode("sw", 4'd3);
      cyc("sw_exec", 3'd2, C_EX_MEM, S_NONE);
      mem_ready = 1'b1;
      cyc("sw_mem", 3'd3, C_MEM_SW, S_NONE);
      mem_ready = 1'b0;
      cyc("sw_done", 3'd0, C_IDLE, S_DONE);

      // BEQ taken and not taken
      fetch_decode("beq1", 4'd4);
      zero = 1'b1;
      cyc("beq1_exec", 3'd2, C_EX_BEQ1, S_NONE);
      zero = 1'b0;
      cyc("beq1_done", 3'd0, C_IDLE, S_DONE);
      fetch_decode("beq0", 4'd4);
      cyc("beq0_exec", 3'd2, C_EX_BEQ0, S_NONE);
      cyc("beq0_done", 3'd0, C_IDLE, S_DONE);

      // SW timeout: counter 0..15 in MEM, abort when it reaches 15 still not ready
      fetch_decode("swto", 4'd3);
      cyc("swto_exec", 3'd2, C_EX_MEM, S_NONE);
      for (int i = 0; i < 16; i++) begin
         cyc("swto_mem", 3'd3, C_MEM_SW, S_NONE);
      end
      cyc("swto_abort", 3'd0, C_IDLE, S_TO);
      cyc("swto_after", 3'd0, C_IDLE, S_NONE);

      // SW ready exactly when the counter reaches 15: completion wins
      fetch_decode("swrace", 4'd3);
      cyc("swrace_exec", 3'd2, C_EX_MEM, S_NONE);
      for (int i = 0; i < 15; i++) begin
         cyc("swrace_mem", 3'd3, C_MEM_SW, S_NONE);
      end
      mem_ready = 1'b1;
      cyc("swrace_rdy", 3'd3, C_MEM_SW, S_NONE);
      mem_ready = 1'b0;
      cyc("swrace_done", 3'd0, C_IDLE, S_DONE);

      // Fetch timeout
      go        = 1'b1;
      mem_ready = 1'b0;
      opcode    = 4'd0;
      for (int i = 0; i < 16; i++) begin
         cyc("fto_wait", 3'd0, C_FETCH_WAIT, S_NONE);
      end
      go = 1'b0;
      cyc("fto_pulse", 3'd0, C_IDLE, S_TO);

      // Illegal opcode
      fetch_decode("ill", 4'd7);
      cyc("ill_pulse", 3'd0, C_IDLE, S_ILL);
      cyc("ill_after", 3'd0, C_IDLE, S_NONE);

      // Opcode change during EXEC is ignored
      fetch_decode("chg", 4'd0);
      opcode = 4'd3;
      cyc("chg_exec", 3'd2, C_EX_R, S_NONE);
      opcode = 4'd7;
      cyc("chg_wb",   3'd4, C_WB_R, S_NONE);
      cyc("chg_done", 3'd0, C_IDLE, S_DONE);

      // Asynchronous reset in the middle of WB
      fetch_decode("rst", 4'd0);
      cyc("rst_exec", 3'd2, C_EX_R, S_NONE);
      @(negedge clk);
      check("rst_wb_rw", {31'd0, RegWrite}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_ctl",   {22'd0, ctl},   32'd0);
      check("rst_stat",  {29'd0, stat},  32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      cyc("rst_after", 3'd0, C_IDLE, S_NONE);
      fetch_decode("post", 4'd1);
      cyc("post_exec", 3'd2, C_EX_I, S_NONE);
      cyc("post_wb",   3'd4, C_WB_I, S_NONE);
      cyc("post_done", 3'd0, C_IDLE, S_DONE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
